// File: rtl/rd_resp_reorder.sv
// Read-response return path: captures out-of-order acks from several master channels
// and hands them to the slave port in request-issue order over valid/ready.
module rd_resp_reorder #(
    parameter int DWIDTH      = 32,
    parameter int NUM_MASTERS = 4,
    parameter int DEPTH       = 4,
    localparam int IDW        = $clog2(NUM_MASTERS)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          req_push,
    input  logic [IDW-1:0]                req_id,
    output logic                          req_ready,
    input  logic [NUM_MASTERS*DWIDTH-1:0] in_rdata,
    input  logic [NUM_MASTERS-1:0]        in_resp,
    input  logic [NUM_MASTERS-1:0]        in_ack,
    output logic [DWIDTH-1:0]             out_rdata,
    output logic                          out_resp,
    output logic [IDW-1:0]                out_id,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          err_unexpected
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = DWIDTH + 1;

    logic [IDW-1:0] ord_mem [DEPTH];
    logic [AW-1:0]  ord_wr_q, ord_wr_d, ord_rd_q, ord_rd_d;
    logic [CW-1:0]  ord_cnt_q, ord_cnt_d;
    logic           req_ready_q, req_ready_d;

    logic [EW-1:0]  rsp_mem   [NUM_MASTERS][DEPTH];
    logic [AW-1:0]  rsp_wr_q  [NUM_MASTERS];
    logic [AW-1:0]  rsp_wr_d  [NUM_MASTERS];
    logic [AW-1:0]  rsp_rd_q  [NUM_MASTERS];
    logic [AW-1:0]  rsp_rd_d  [NUM_MASTERS];
    logic [CW-1:0]  rsp_cnt_q [NUM_MASTERS];
    logic [CW-1:0]  rsp_cnt_d [NUM_MASTERS];
    logic [CW-1:0]  pend_q    [NUM_MASTERS];
    logic [CW-1:0]  pend_d    [NUM_MASTERS];

    logic              out_valid_q, out_valid_d;
    logic [IDW-1:0]    out_id_q, out_id_d;
    logic              out_resp_q, out_resp_d;
    logic [DWIDTH-1:0] out_rdata_q, out_rdata_d;
    logic              err_q, err_d;

    logic                   push_acc;
    logic                   load;
    logic                   bypass;
    logic [IDW-1:0]         head_id;
    logic [EW-1:0]          load_data;
    logic [NUM_MASTERS-1:0] ack_acc;
    logic [NUM_MASTERS-1:0] rsp_wr;
    logic [NUM_MASTERS-1:0] rsp_pop;
    logic                   push_m;

    always_comb begin
        push_acc = req_push && req_ready_q;
        head_id  = ord_mem[ord_rd_q];
        for (int m = 0; m < NUM_MASTERS; m++) begin
            ack_acc[m] = in_ack[m] && (pend_q[m] != '0);
        end

        // An ack for the head request goes straight to the output when its FIFO is empty
        load   = 1'b0;
        bypass = 1'b0;
        if ((!out_valid_q || out_ready) && (ord_cnt_q != '0)) begin
            if (rsp_cnt_q[head_id] != '0) begin
                load = 1'b1;
            end else if (ack_acc[head_id]) begin
                load   = 1'b1;
                bypass = 1'b1;
            end
        end
        load_data = bypass ? {in_resp[head_id], in_rdata[head_id*DWIDTH +: DWIDTH]}
                           : rsp_mem[head_id][rsp_rd_q[head_id]];

        for (int m = 0; m < NUM_MASTERS; m++) begin
            push_m     = push_acc && (req_id == IDW'(m));
            rsp_wr[m]  = ack_acc[m] && !(bypass && (head_id == IDW'(m)));
            rsp_pop[m] = load && !bypass && (head_id == IDW'(m));

            pend_d[m] = pend_q[m];
            if (push_m && !ack_acc[m]) begin
                pend_d[m] = pend_q[m] + CW'(1);
            end else if (!push_m && ack_acc[m]) begin
                pend_d[m] = pend_q[m] - CW'(1);
            end

            rsp_cnt_d[m] = rsp_cnt_q[m];
            if (rsp_wr[m] && !rsp_pop[m]) begin
                rsp_cnt_d[m] = rsp_cnt_q[m] + CW'(1);
            end else if (!rsp_wr[m] && rsp_pop[m]) begin
                rsp_cnt_d[m] = rsp_cnt_q[m] - CW'(1);
            end
            rsp_wr_d[m] = rsp_wr[m]  ? rsp_wr_q[m] + AW'(1) : rsp_wr_q[m];
            rsp_rd_d[m] = rsp_pop[m] ? rsp_rd_q[m] + AW'(1) : rsp_rd_q[m];
        end
        push_m = 1'b0;

        ord_wr_d  = push_acc ? ord_wr_q + AW'(1) : ord_wr_q;
        ord_rd_d  = load     ? ord_rd_q + AW'(1) : ord_rd_q;
        ord_cnt_d = ord_cnt_q;
        if (push_acc && !load) begin
            ord_cnt_d = ord_cnt_q + CW'(1);
        end else if (!push_acc && load) begin
            ord_cnt_d = ord_cnt_q - CW'(1);
        end
        req_ready_d = (ord_cnt_d != CW'(DEPTH));

        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_resp_d  = out_resp_q;
        out_rdata_d = out_rdata_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_id_d    = head_id;
            out_resp_d  = load_data[DWIDTH];
            out_rdata_d = load_data[DWIDTH-1:0];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        err_d = err_q || ((in_ack & ~ack_acc) != '0);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ord_wr_q    <= '0;
            ord_rd_q    <= '0;
            ord_cnt_q   <= '0;
            req_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_resp_q  <= 1'b0;
            out_rdata_q <= '0;
            err_q       <= 1'b0;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                pend_q[m]    <= '0;
                rsp_wr_q[m]  <= '0;
                rsp_rd_q[m]  <= '0;
                rsp_cnt_q[m] <= '0;
            end
        end else begin
            ord_wr_q    <= ord_wr_d;
            ord_rd_q    <= ord_rd_d;
            ord_cnt_q   <= ord_cnt_d;
            req_ready_q <= req_ready_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_resp_q  <= out_resp_d;
            out_rdata_q <= out_rdata_d;
            err_q       <= err_d;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                pend_q[m]    <= pend_d[m];
                rsp_wr_q[m]  <= rsp_wr_d[m];
                rsp_rd_q[m]  <= rsp_rd_d[m];
                rsp_cnt_q[m] <= rsp_cnt_d[m];
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and counts above
    always_ff @(posedge aclk) begin
        if (push_acc) begin
            ord_mem[ord_wr_q] <= req_id;
        end
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (rsp_wr[m]) begin
                rsp_mem[m][rsp_wr_q[m]] <= {in_resp[m], in_rdata[m*DWIDTH +: DWIDTH]};
            end
        end
    end

    assign req_ready      = req_ready_q;
    assign out_valid      = out_valid_q;
    assign out_id         = out_id_q;
    assign out_resp       = out_resp_q;
    assign out_rdata      = out_rdata_q;
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_rd_resp_reorder.sv
// Bench for rd_resp_reorder: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_rd_resp_reorder;
    localparam int DW  = 32;
    localparam int NM  = 4;
    localparam int DEP = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           req_push;
    logic [IDW-1:0] req_id;
    logic           req_ready;
    logic [NM*DW-1:0] in_rdata;
    logic [NM-1:0]  in_resp;
    logic [NM-1:0]  in_ack;
    logic [DW-1:0]  out_rdata;
    logic           out_resp;
    logic [IDW-1:0] out_id;
    logic           out_valid;
    logic           out_ready;
    logic           err_unexpected;

    int nchecks = 0;
    int nerrors = 0;

    rd_resp_reorder #(.DWIDTH(DW), .NUM_MASTERS(NM), .DEPTH(DEP)) dut (
        .aclk(clk), .aresetn(rst_n),
        .req_push(req_push), .req_id(req_id), .req_ready(req_ready),
        .in_rdata(in_rdata), .in_resp(in_resp), .in_ack(in_ack),
        .out_rdata(out_rdata), .out_resp(out_resp), .out_id(out_id),
        .out_valid(out_valid), .out_ready(out_ready),
        .err_unexpected(err_unexpected)
    );

    // Reference model: request order queue, per-master response queues, output register
    int          oq[$];
    logic [DW:0] rq[NM][$];
    int          m_out[NM];
    logic        m_valid, m_resp, m_err, m_ready;
    logic [DW-1:0] m_data;
    int          m_id;

    task automatic model_step();
        int h;
        logic free;
        logic [DW:0] e;
        if (!rst_n) begin
            oq.delete();
            for (int m = 0; m < NM; m++) begin
                rq[m].delete();
                m_out[m] = 0;
            end
            m_valid = 0; m_resp = 0; m_err = 0; m_ready = 0; m_data = '0; m_id = 0;
            return;
        end
        free = !m_valid || out_ready;
        for (int m = 0; m < NM; m++) begin
            if (in_ack[m]) begin
                if (m_out[m] > 0) begin
                    m_out[m]--;
                    rq[m].push_back({in_resp[m], in_rdata[m*DW +: DW]});
                end else begin
                    m_err = 1;
                end
            end
        end
        if (req_push && m_ready) begin
            oq.push_back(int'(req_id));
            m_out[req_id]++;
        end
        if (free) begin
            m_valid = 0;
            if (oq.size() > 0) begin
                h = oq[0];
                if (rq[h].size() > 0) begin
                    e = rq[h].pop_front();
                    void'(oq.pop_front());
                    m_valid = 1;
                    m_id    = h;
                    m_resp  = e[DW];
                    m_data  = e[DW-1:0];
                end
            end
        end
        m_ready = (oq.size() < DEP);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        req_push = 1'b0;
        in_ack   = '0;
        in_resp  = '0;
    endtask

    task automatic set_ack(input int m, input logic r, input logic [DW-1:0] d);
        in_ack[m]          = 1'b1;
        in_resp[m]         = r;
        in_rdata[m*DW +: DW] = d;
    endtask

    task automatic push(input int id);
        req_push = 1'b1;
        req_id   = IDW'(id);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
        nchecks++; if (out_rdata !== '0) begin nerrors++; $display("FAIL reset_rdata: got %h, expected 0", out_rdata); end
        nchecks++; if (out_resp !== 1'b0) begin nerrors++; $display("FAIL reset_resp: got %b, expected 0", out_resp); end
        nchecks++; if (out_id !== '0) begin nerrors++; $display("FAIL reset_id: got %0d, expected 0", out_id); end
        nchecks++; if (err_unexpected !== 1'b0) begin nerrors++; $display("FAIL reset_err: got %b, expected 0", err_unexpected); end
        nchecks++; if (req_ready !== 1'b0) begin nerrors++; $display("FAIL reset_ready: got %b, expected 0", req_ready); end
        rst_n = 1'b1;
        tick();
        nchecks++; if (req_ready !== 1'b1) begin nerrors++; $display("FAIL ready_after_reset: got %b, expected 1", req_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        push(2);
        tick();
        tick();
        set_ack(2, 1'b0, 32'hDEADBEEF);
        tick();
        nchecks++; if (out_valid !== 1'b1) begin nerrors++; $display("FAIL single_valid: got %b, expected 1", out_valid); end
        nchecks++; if (out_id !== 2'd2) begin nerrors++; $display("FAIL single_id: got %0d, expected 2", out_id); end
        nchecks++; if (out_rdata !== 32'hDEADBEEF) begin nerrors++; $display("FAIL single_rdata: got %h, expected deadbeef", out_rdata); end
        nchecks++; if (out_resp !== 1'b0) begin nerrors++; $display("FAIL single_resp: got %b, expected 0", out_resp); end
        tick();
        nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL single_drain: got %b, expected 0", out_valid); end
    endtask

    task automatic test_reorder();
        int exp_id[3];
        logic [DW-1:0] exp_d[3];
        exp_id = '{0, 1, 3};
        exp_d  = '{32'h00, 32'h11, 32'h33};
        out_ready = 1'b1;
        push(0); tick();
        push(1); tick();
        push(3); tick();
        set_ack(3, 1'b0, 32'h33); tick();
        set_ack(1, 1'b0, 32'h11); tick();
        nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL reorder_wait_head: got %b, expected 0", out_valid); end
        set_ack(0, 1'b0, 32'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            nchecks++; if (out_valid !== 1'b1 || out_id !== IDW'(exp_id[i]) || out_rdata !== exp_d[i]) begin
                nerrors++; $display("FAIL reorder_out%0d: got v=%b id=%0d d=%h, expected v=1 id=%0d d=%h", i, out_valid, out_id, out_rdata, exp_id[i], exp_d[i]);
            end
        end
        tick();
        nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL reorder_drain: got %b, expected 0", out_valid); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(1);
            tick();
        end
        nchecks++; if (req_ready !== 1'b0) begin nerrors++; $display("FAIL full_ready: got %b, expected 0", req_ready); end
        push(1);
        tick();
        nchecks++; if (req_ready !== 1'b0) begin nerrors++; $display("FAIL full_ignored_push: got %b, expected 0", req_ready); end
        for (int i = 0; i < 4; i++) begin
            set_ack(1, 1'b0, 32'hA0 + i);
            tick();
        end
        nchecks++; if (out_valid !== 1'b1 || out_rdata !== 32'hA0) begin nerrors++; $display("FAIL full_hold: got v=%b d=%h, expected v=1 d=000000a0", out_valid, out_rdata); end
        tick();
        nchecks++; if (out_rdata !== 32'hA0) begin nerrors++; $display("FAIL full_hold2: got %h, expected 000000a0", out_rdata); end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            nchecks++; if (out_valid !== 1'b1 || out_rdata !== 32'hA0 + i) begin nerrors++; $display("FAIL full_drain%0d: got v=%b d=%h, expected v=1 d=%h", i, out_valid, out_rdata, 32'hA0 + i); end
        end
        tick();
        nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL full_empty: got %b, expected 0", out_valid); end
        nchecks++; if (req_ready !== 1'b1) begin nerrors++; $display("FAIL full_ready_back: got %b, expected 1", req_ready); end
        // The rejected fifth push must leave nothing outstanding on channel 1
        set_ack(1, 1'b0, 32'hBAD);
        tick();
        nchecks++; if (err_unexpected !== 1'b1) begin nerrors++; $display("FAIL full_no_fifth: got %b, expected 1", err_unexpected); end
    endtask

    task automatic test_err_simul();
        out_ready = 1'b1;
        push(0); tick();
        push(1); tick();
        set_ack(0, 1'b1, 32'hE0);
        set_ack(1, 1'b0, 32'hE1);
        tick();
        nchecks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_resp !== 1'b1 || out_rdata !== 32'hE0) begin
            nerrors++; $display("FAIL simul_first: got v=%b id=%0d r=%b d=%h, expected v=1 id=0 r=1 d=000000e0", out_valid, out_id, out_resp, out_rdata);
        end
        tick();
        nchecks++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_resp !== 1'b0 || out_rdata !== 32'hE1) begin
            nerrors++; $display("FAIL simul_second: got v=%b id=%0d r=%b d=%h, expected v=1 id=1 r=0 d=000000e1", out_valid, out_id, out_resp, out_rdata);
        end
        nchecks++; if (err_unexpected !== 1'b0) begin nerrors++; $display("FAIL simul_err: got %b, expected 0", err_unexpected); end
        tick();
    endtask

    task automatic test_unexpected();
        do_reset();
        out_ready = 1'b1;
        set_ack(2, 1'b0, 32'h99);
        tick();
        nchecks++; if (err_unexpected !== 1'b1) begin nerrors++; $display("FAIL unexp_err: got %b, expected 1", err_unexpected); end
        nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL unexp_noout: got %b, expected 0", out_valid); end
        do_reset();
        push(2);
        set_ack(2, 1'b0, 32'h98);
        tick();
        nchecks++; if (err_unexpected !== 1'b1) begin nerrors++; $display("FAIL same_cycle_err: got %b, expected 1", err_unexpected); end
        set_ack(2, 1'b0, 32'h22);
        tick();
        nchecks++; if (out_valid !== 1'b1 || out_id !== 2'd2 || out_rdata !== 32'h22) begin
            nerrors++; $display("FAIL same_cycle_later: got v=%b id=%0d d=%h, expected v=1 id=2 d=00000022", out_valid, out_id, out_rdata);
        end
        tick();
    endtask

    task automatic test_midreset();
        do_reset();
        out_ready = 1'b1;
        push(0); tick();
        push(1); tick();
        push(2); tick();
        rst_n = 1'b0;
        tick();
        nchecks++; if (out_valid !== 1'b0 || out_rdata !== '0 || out_resp !== 1'b0 || out_id !== '0 || err_unexpected !== 1'b0 || req_ready !== 1'b0) begin
            nerrors++; $display("FAIL midreset_outs: got v=%b d=%h r=%b id=%0d e=%b rdy=%b, expected all 0", out_valid, out_rdata, out_resp, out_id, err_unexpected, req_ready);
        end
        rst_n = 1'b1;
        tick();
        nchecks++; if (req_ready !== 1'b1) begin nerrors++; $display("FAIL midreset_ready: got %b, expected 1", req_ready); end
        set_ack(1, 1'b0, 32'h51);
        tick();
        nchecks++; if (err_unexpected !== 1'b1) begin nerrors++; $display("FAIL midreset_stale: got %b, expected 1", err_unexpected); end
        nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL midreset_noout: got %b, expected 0", out_valid); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 699) != 0);
            req_push  = ($urandom_range(0, 1) == 1);
            req_id    = IDW'($urandom_range(0, NM - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int m = 0; m < NM; m++) begin
                if (m_out[m] > 0 && $urandom_range(0, 2) == 0) begin
                    set_ack(m, 1'($urandom_range(0, 1)), $urandom);
                end
            end
            if ($urandom_range(0, 299) == 0) in_ack[$urandom_range(0, NM - 1)] = 1'b1;
            tick();
            nchecks++; if (req_ready !== m_ready) begin nerrors++; $display("FAIL rand_ready c=%0d: got %b, expected %b", c, req_ready, m_ready); end
            nchecks++; if (out_valid !== m_valid) begin nerrors++; $display("FAIL rand_valid c=%0d: got %b, expected %b", c, out_valid, m_valid); end
            nchecks++; if (err_unexpected !== m_err) begin nerrors++; $display("FAIL rand_err c=%0d: got %b, expected %b", c, err_unexpected, m_err); end
            if (m_valid) begin
                nchecks++; if (out_id !== IDW'(m_id) || out_resp !== m_resp || out_rdata !== m_data) begin
                    nerrors++; $display("FAIL rand_data c=%0d: got id=%0d r=%b d=%h, expected id=%0d r=%b d=%h", c, out_id, out_resp, out_rdata, m_id, m_resp, m_data);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_push  = 1'b0;
        req_id    = '0;
        in_rdata  = '0;
        in_resp   = '0;
        in_ack    = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_reorder();
        test_full();
        do_reset();
        test_err_simul();
        test_unexpected();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
